cache_write_buffer: RTL and testbench

- Posted-write FIFO between the MIPS CPU data port and the Avalon memory bus.
- Accepts CPU stores in a single cycle, queues them, and drains them to memory while the cache controller holds `active` high.
- Reports full and empty status, and exposes an address-match flag so the controller can keep reads coherent with queued writes.

---
 rtl/cache_write_buffer.sv | 152 +++++++++++++++
 tb/tb_cache_write_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_write_buffer.sv
// Posted-write FIFO between the CPU data port and the Avalon bus, with read-coherence address match.
// Optional store coalescing into the tail entry is enabled by defining WB_MERGE_EN.

package cache_write_buffer_pkg;

    typedef struct packed {
        logic [29:0] word;
        logic [31:0] data;
        logic [3:0]  be;
    } wb_entry_t;

endpackage

module cache_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        write_en,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    input  logic        active,
    input  logic        waitrequest,
    output logic        addr_in_wb,
    output logic [31:0] write_addr,
    output logic [31:0] write_data,
    output logic [3:0]  write_byteenable,
    output logic        write_writeenable,
    output logic [1:0]  state_out,
    output logic        full,
    output logic        empty
);
    import cache_write_buffer_pkg::*;

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_WRITING = 2'd2;

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;

    wb_entry_t          head_entry_c;
    wb_entry_t          new_entry_c;
    logic               push_c;
    logic               pop_c;
    logic               merge_c;
    logic               unused_addr_c;

    // Byte-offset bits never participate in word matching.
    assign unused_addr_c = ^addr[1:0];

    assign empty             = (count_q == '0);
    assign full              = (count_q == CNT_W'(DEPTH));
    assign write_writeenable = active && !empty;
    assign pop_c             = write_writeenable && !waitrequest;

    // Head entry is masked to zero when nothing is queued.
    assign head_entry_c     = empty ? '0 : mem_q[head_q];
    assign write_addr       = {head_entry_c.word, 2'b00};
    assign write_data       = head_entry_c.data;
    assign write_byteenable = head_entry_c.be;

    assign new_entry_c.word = addr[31:2];
    assign new_entry_c.data = writedata;
    assign new_entry_c.be   = byteenable;

    always_comb begin
        state_out = ST_EMPTY;
        if (write_writeenable) begin
            state_out = ST_WRITING;
        end else if (!empty) begin
            state_out = ST_PENDING;
        end
    end

    // Match only slots lying within [head, head+count); the head stays valid until its pop edge.
    always_comb begin
        addr_in_wb = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(PTR_W'(PTR_W'(i) - head_q)) < count_q) &&
                (mem_q[i].word == addr[31:2])) begin
                addr_in_wb = 1'b1;
            end
        end
    end

`ifdef WB_MERGE_EN
    logic [PTR_W-1:0] tail_last_c;
    wb_entry_t        tail_entry_c;
    wb_entry_t        merged_entry_c;

    assign tail_last_c  = tail_q - PTR_W'(1);
    assign tail_entry_c = mem_q[tail_last_c];

    // Coalesce unless the tail is the sole entry and is on the bus right now.
    assign merge_c = write_en && !empty &&
                     (tail_entry_c.word == addr[31:2]) &&
                     !(write_writeenable && (count_q == CNT_W'(1)));

    always_comb begin
        merged_entry_c = tail_entry_c;
        for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) begin
                merged_entry_c.data[8*b +: 8] = writedata[8*b +: 8];
                merged_entry_c.be[b]          = 1'b1;
            end
        end
    end
`else
    assign merge_c = 1'b0;
`endif

    // A full buffer still accepts a store when the head pops on the same edge.
    assign push_c = write_en && !merge_c && (!full || pop_c);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mem_q[tail_q] <= new_entry_c;
                tail_q        <= tail_q + PTR_W'(1);
            end
`ifdef WB_MERGE_EN
            if (merge_c) begin
                mem_q[tail_last_c] <= merged_entry_c;
            end
`endif
            if (pop_c) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed self-checking bench for cache_write_buffer (DEPTH=4).
// Merge expectations follow WB_MERGE_EN when it is defined for the build.

module tb_cache_write_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        write_en;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        active;
    logic        waitrequest;
    logic        addr_in_wb;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic [3:0]  write_byteenable;
    logic        write_writeenable;
    logic [1:0]  state_out;
    logic        full;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];

    cache_write_buffer #(.DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .addr              (addr),
        .write_en          (write_en),
        .writedata         (writedata),
        .byteenable        (byteenable),
        .active            (active),
        .waitrequest       (waitrequest),
        .addr_in_wb        (addr_in_wb),
        .write_addr        (write_addr),
        .write_data        (write_data),
        .write_byteenable  (write_byteenable),
        .write_writeenable (write_writeenable),
        .state_out         (state_out),
        .full              (full),
        .empty             (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        write_en   = 1'b1;
        addr       = a;
        writedata  = d;
        byteenable = be;
        tick();
        write_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b0; addr = '0; write_en = 1'b0; writedata = '0;
        byteenable = '0; active = 1'b0; waitrequest = 1'b0;
        #3;

        // Reset state
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wwe", 32'(write_writeenable), 32'd0);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_match", 32'(addr_in_wb), 32'd0);
        chk("rst_waddr", write_addr, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Single push, held off the bus
        push(32'h100, 32'hDEADBEEF, 4'hF);
        addr = 32'h102;
        #1;
        chk("p1_empty", 32'(empty), 32'd0);
        chk("p1_state", 32'(state_out), 32'd1);
        chk("p1_wwe", 32'(write_writeenable), 32'd0);
        chk("p1_match", 32'(addr_in_wb), 32'd1);
        addr = 32'h104;
        #1;
        chk("p1_nomatch", 32'(addr_in_wb), 32'd0);

        // Stalled write: stable for 4 cycles, pops on the 4th edge
        active = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waitrequest = (k < 3);
            #1;
            chk("stall_wwe", 32'(write_writeenable), 32'd1);
            chk("stall_state", 32'(state_out), 32'd2);
            chk("stall_addr", write_addr, 32'h100);
            chk("stall_data", write_data, 32'hDEADBEEF);
            tick();
        end
        active = 1'b0;
        #1;
        chk("pop1_empty", 32'(empty), 32'd1);
        chk("pop1_state", 32'(state_out), 32'd0);

        // Fill to full, then drop a fifth store
        for (int k = 0; k < 4; k++) begin
            push(32'h400 + 32'(4 * k), 32'(k + 1), 4'hF);
            #1;
            chk("fill_full", 32'(full), 32'(k == 3));
        end
        push(32'h200, 32'h55, 4'hF);
        addr = 32'h200;
        #1;
        chk("drop_match", 32'(addr_in_wb), 32'd0);
        chk("drop_full", 32'(full), 32'd1);
        addr = 32'h408;
        #1;
        chk("full_match", 32'(addr_in_wb), 32'd1);

        // Push into a full buffer on the pop edge
        active = 1'b1; waitrequest = 1'b0;
        write_en = 1'b1; addr = 32'h300; writedata = 32'h33; byteenable = 4'hF;
        #1;
        chk("fp_head", write_addr, 32'h400);
        chk("fp_full", 32'(full), 32'd1);
        tick();
        write_en = 1'b0;
        #1;
        chk("fp_full_after", 32'(full), 32'd1);
        exp_a[0] = 32'h404; exp_a[1] = 32'h408; exp_a[2] = 32'h40C; exp_a[3] = 32'h300;
        exp_d[0] = 32'h2;   exp_d[1] = 32'h3;   exp_d[2] = 32'h4;   exp_d[3] = 32'h33;
        for (int k = 0; k < 4; k++) begin
            chk("order_addr", write_addr, exp_a[k]);
            chk("order_data", write_data, exp_d[k]);
            tick();
            if (k == 0) chk("order_notfull", 32'(full), 32'd0);
        end
        chk("order_empty", 32'(empty), 32'd1);
        active = 1'b0;

        // Same-word stores: coalesced or queued separately
        push(32'h10, 32'h11, 4'b0001);
        push(32'h10, 32'h2200, 4'b0010);
        active = 1'b1; waitrequest = 1'b0;
        #1;
`ifdef WB_MERGE_EN
        chk("merge_addr", write_addr, 32'h10);
        chk("merge_be", 32'(write_byteenable), 32'h3);
        chk("merge_data", write_data, 32'h2211);
        tick();
        chk("merge_empty", 32'(empty), 32'd1);
`else
        chk("sep1_be", 32'(write_byteenable), 32'h1);
        chk("sep1_data", write_data, 32'h11);
        tick();
        chk("sep2_addr", write_addr, 32'h10);
        chk("sep2_be", 32'(write_byteenable), 32'h2);
        chk("sep2_data", write_data, 32'h2200);
        tick();
        chk("sep_empty", 32'(empty), 32'd1);
`endif
        active = 1'b0;

        // Asynchronous reset during a stalled write
        push(32'h500, 32'hA, 4'hF);
        push(32'h504, 32'hB, 4'hF);
        push(32'h508, 32'hC, 4'hF);
        active = 1'b1; waitrequest = 1'b1;
        #1;
        chk("mid_wwe", 32'(write_writeenable), 32'd1);
        addr = 32'h500;
        #1;
        rst = 1'b0;
        #1;
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_wwe", 32'(write_writeenable), 32'd0);
        chk("arst_state", 32'(state_out), 32'd0);
        chk("arst_match", 32'(addr_in_wb), 32'd0);
        chk("arst_waddr", write_addr, 32'd0);
        tick();
        rst = 1'b1; active = 1'b0; waitrequest = 1'b0;
        tick();

        // Dropping active mid-entry re-presents the same head later
        push(32'h600, 32'h66, 4'hF);
        active = 1'b1; waitrequest = 1'b1;
        #1;
        chk("act_wwe_on", 32'(write_writeenable), 32'd1);
        active = 1'b0;
        #1;
        chk("act_wwe_off", 32'(write_writeenable), 32'd0);
        chk("act_state", 32'(state_out), 32'd1);
        tick();
        chk("act_head", write_addr, 32'h600);
        active = 1'b1; waitrequest = 1'b0;
        #1;
        chk("act_data", write_data, 32'h66);
        tick();
        chk("act_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
